divider_seq: RTL and testbench



---
 rtl/alu_types_pkg.sv | 18 +
 rtl/adder_n.sv | 16 +
 rtl/divider_seq.sv | 157 +++++++++++++++
 tb/tb_divider_seq.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_types_pkg.sv
// Shared types and constants for the ALU-side execution units.
// Holds the divider state encoding and the divide-by-zero quotient pattern.
package alu_types_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } div_state_t;

  localparam int unsigned MAX_W = 64;

  // All-ones pattern of the requested width, right-aligned in a MAX_W word.
  function automatic logic [MAX_W-1:0] div_zero_quotient(input int unsigned width);
    return {MAX_W{1'b1}} >> (MAX_W - width);
  endfunction

endpackage

// File: rtl/adder_n.sv
// Plain N-bit ripple-style adder with carry in and carry out.
// The divider uses it as a subtractor by feeding the inverted divisor and c_in=1.
module adder_n #(
  parameter int N = 33
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         c_in,
  output logic [N-1:0] sum,
  output logic         c_out
);

  // Full-width sum; the extra top bit is the carry out.
  assign {c_out, sum} = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, c_in};

endmodule

// File: rtl/divider_seq.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock,
// with valid/ready handshakes on operands and results.
module divider_seq
  import alu_types_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_valid,
  output logic         i_ready,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         o_valid,
  input  logic         o_ready,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);

  localparam int CNT_W = $clog2(N);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);
  localparam logic [N-1:0] DIV_ZERO_QUOTIENT = N'(div_zero_quotient(N));

  div_state_t     state;
  div_state_t     state_next;
  logic [N-1:0]   q_reg;
  logic [N:0]     r_reg;
  logic [N-1:0]   divisor_reg;
  logic [CNT_W-1:0] cnt;
  logic [N:0]     shifted;
  logic [N:0]     divisor_inv;
  logic [N:0]     trial;
  logic           no_borrow;
  logic [N-1:0]   q_next;
  logic [N:0]     r_next;
  logic           divisor_zero;
  logic           last_iter;
  logic           unused_r_msb;

  assign i_ready      = (state == S_IDLE);
  assign o_valid      = (state == S_DONE);
  assign divisor_zero = (divisor == {N{1'b0}});
  assign last_iter    = (cnt == LAST_CNT);
  assign shifted      = {r_reg[N-1:0], q_reg[N-1]};
  assign divisor_inv  = ~{1'b0, divisor_reg};
  // The restored remainder is always below the divisor, so its top bit never feeds back.
  assign unused_r_msb = r_reg[N];

  adder_n #(
    .N(N + 1)
  ) u_trial (
    .a    (shifted),
    .b    (divisor_inv),
    .c_in (1'b1),
    .sum  (trial),
    .c_out(no_borrow)
  );

  // Keep the trial difference when it did not borrow, else restore the shifted value.
  always_comb begin
    r_next = shifted;
    q_next = {q_reg[N-2:0], 1'b0};
    if (no_borrow) begin
      r_next = trial;
      q_next = {q_reg[N-2:0], 1'b1};
    end else begin
      r_next = shifted;
      q_next = {q_reg[N-2:0], 1'b0};
    end
  end

  // Next-state decode.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (i_valid) begin
          if (divisor_zero) begin
            state_next = S_DONE;
          end else begin
            state_next = S_RUN;
          end
        end else begin
          state_next = S_IDLE;
        end
      end
      S_RUN: begin
        if (last_iter) begin
          state_next = S_DONE;
        end else begin
          state_next = S_RUN;
        end
      end
      S_DONE: begin
        if (o_ready) begin
          state_next = S_IDLE;
        end else begin
          state_next = S_DONE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Datapath and result registers; results only change on entry to DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_reg       <= {N{1'b0}};
      r_reg       <= {(N + 1){1'b0}};
      divisor_reg <= {N{1'b0}};
      cnt         <= {CNT_W{1'b0}};
      quotient    <= {N{1'b0}};
      remainder   <= {N{1'b0}};
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_valid) begin
            if (divisor_zero) begin
              quotient    <= DIV_ZERO_QUOTIENT;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end else begin
              divisor_reg <= divisor;
              q_reg       <= dividend;
              r_reg       <= {(N + 1){1'b0}};
              cnt         <= {CNT_W{1'b0}};
            end
          end
        end
        S_RUN: begin
          q_reg <= q_next;
          r_reg <= r_next;
          cnt   <= cnt + 1'b1;
          if (last_iter) begin
            quotient    <= q_next;
            remainder   <= r_next[N-1:0];
            div_by_zero <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_divider_seq.sv
// Self-checking bench for divider_seq: directed corner cases, backpressure,
// mid-operation reset and randomized operands against an arithmetic model.
module tb_divider_seq;

  localparam int N = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_valid;
  logic         i_ready;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic         o_valid;
  logic         o_ready;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         div_by_zero;

  divider_seq #(.N(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_valid    (i_valid),
    .i_ready    (i_ready),
    .dividend   (dividend),
    .divisor    (divisor),
    .o_valid    (o_valid),
    .o_ready    (o_ready),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         dz;
    int           acc;
  } exp_t;

  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  exp_t exp_q[$];
  bit   rand_ready = 1'b0;
  logic prev_valid = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, req, $time);
    end
  endtask

  // Reference: plain integer division, with the divide-by-zero convention.
  function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b);
    exp_t e;
    if (b == 0) begin
      e.q  = '1;
      e.r  = a;
      e.dz = 1'b1;
    end else begin
      e.q  = a / b;
      e.r  = a % b;
      e.dz = 1'b0;
    end
    e.acc = 0;
    return e;
  endfunction

  function automatic exp_t lit(input logic [N-1:0] q, input logic [N-1:0] r, input logic dz);
    exp_t e;
    e.q = q; e.r = r; e.dz = dz; e.acc = 0;
    return e;
  endfunction

  // Compare process: outputs checked every cycle o_valid is high.
  always @(negedge clk) begin
    if (rst) begin
      prev_valid <= 1'b0;
    end else begin
      if (exp_q.size() != 0) chk("i_ready_busy", 64'(i_ready), 64'd0);
      if (o_valid) begin
        if (exp_q.size() == 0) begin
          chk("o_valid_unexpected", 64'(o_valid), 64'd0);
        end else begin
          if (!prev_valid)
            chk("latency", 64'(cyc - exp_q[0].acc), exp_q[0].dz ? 64'd1 : 64'(N + 1));
          chk("quotient", 64'(quotient), 64'(exp_q[0].q));
          chk("remainder", 64'(remainder), 64'(exp_q[0].r));
          chk("div_by_zero", 64'(div_by_zero), 64'(exp_q[0].dz));
          if (o_ready) void'(exp_q.pop_front());
        end
      end
      prev_valid <= o_valid;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) o_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b, input exp_t e);
    int c;
    int guard;
    guard = 0;
    @(negedge clk);
    i_valid  = 1'b1;
    dividend = a;
    divisor  = b;
    while (!i_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!i_ready) begin
      chk("accept_timeout", 64'(i_ready), 64'd1);
      i_valid = 1'b0;
      return;
    end
    c = cyc;
    @(posedge clk);
    e.acc = c;
    exp_q.push_back(e);
    #1;
    i_valid  = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
  endtask

  task automatic wait_drain();
    int guard;
    guard = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || !i_ready) && guard < 600) begin
      @(negedge clk);
      guard++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic run_dir(input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic [N-1:0] q, input logic [N-1:0] r, input logic dz);
    do_op(a, b, lit(q, r, dz));
    wait_drain();
  endtask

  initial begin
    exp_t e;
    logic [N-1:0] a;
    logic [N-1:0] b;
    int guard;

    rst = 1'b1; i_valid = 1'b0; o_ready = 1'b1; dividend = '0; divisor = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_i_ready", 64'(i_ready), 64'd1);
    chk("rst_o_valid", 64'(o_valid), 64'd0);
    chk("rst_quotient", 64'(quotient), 64'd0);
    chk("rst_remainder", 64'(remainder), 64'd0);
    chk("rst_div_by_zero", 64'(div_by_zero), 64'd0);
    @(posedge clk); #1; rst = 1'b0;

    e = model(32'd100, 32'd7);
    chk("model_q_100_7", 64'(e.q), 64'd14);
    chk("model_r_100_7", 64'(e.r), 64'd2);
    e = model(32'h1234_5678, 32'd0);
    chk("model_q_dz", 64'(e.q), 64'hFFFF_FFFF);
    chk("model_dz", 64'(e.dz), 64'd1);

    run_dir(32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
    run_dir(32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1);
    run_dir(32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0);
    run_dir(32'd5, 32'd9, 32'd0, 32'd5, 1'b0);
    run_dir(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0);
    run_dir(32'h8000_0000, 32'd2, 32'h4000_0000, 32'd0, 1'b0);
    run_dir(32'd0, 32'd5, 32'd0, 32'd0, 1'b0);

    // Backpressure: result held for 10 cycles while new operands are offered.
    o_ready = 1'b0;
    do_op(32'd100, 32'd7, lit(32'd14, 32'd2, 1'b0));
    guard = 0;
    while (!o_valid && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    chk("bp_o_valid_seen", 64'(o_valid), 64'd1);
    repeat (10) begin
      @(negedge clk);
      chk("bp_i_ready", 64'(i_ready), 64'd0);
      chk("bp_o_valid", 64'(o_valid), 64'd1);
      chk("bp_quotient", 64'(quotient), 64'd14);
      i_valid = 1'b1; dividend = $urandom; divisor = '0;
    end
    @(posedge clk); #1;
    i_valid = 1'b0; o_ready = 1'b1;
    @(posedge clk); #1;
    o_ready = 1'b0;
    @(negedge clk);
    chk("bp_release_i_ready", 64'(i_ready), 64'd1);
    chk("bp_release_o_valid", 64'(o_valid), 64'd0);
    o_ready = 1'b1;

    // Reset mid-operation aborts without emitting anything.
    do_op(32'd1000, 32'd3, lit(32'd333, 32'd1, 1'b0));
    repeat (15) @(posedge clk);
    #1; rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_o_valid", 64'(o_valid), 64'd0);
    chk("mid_rst_i_ready", 64'(i_ready), 64'd1);
    chk("mid_rst_quotient", 64'(quotient), 64'd0);
    chk("mid_rst_remainder", 64'(remainder), 64'd0);
    chk("mid_rst_div_by_zero", 64'(div_by_zero), 64'd0);
    exp_q.delete();
    @(posedge clk); #1; rst = 1'b0;
    run_dir(32'd1000, 32'd3, 32'd333, 32'd1, 1'b0);

    // Random operands with random result stalls.
    rand_ready = 1'b1;
    for (int i = 0; i < 1200; i++) begin
      a = $urandom;
      case ($urandom_range(0, 9))
        0:       b = '0;
        1, 2:    b = N'($urandom_range(1, 15));
        3:       b = a;
        4:       b = a + 1;
        5:       a = a >> $urandom_range(0, 31);
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      if (i % 10 == 5) b = $urandom;
      do_op(a, b, model(a, b));
    end
    wait_drain();
    rand_ready = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
